// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: word, cacheline and the responder state encoding.
// Pure type package with no logic and no latency.
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} lc3b_pmem_state;
endpackage

// File: rtl/pmem_line_array.sv
// Line storage: combinational read and a one-edge write. The write is visible on the next cycle.
// There is no handshake and no reset; contents persist across rst_n.
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int LINE_IDX_W = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LINE_IDX_W-1:0] widx,
  input  lc3b_cacheline         wdata,
  input  logic [LINE_IDX_W-1:0] ridx,
  output lc3b_cacheline         rdata
);
  lc3b_cacheline mem [2**LINE_IDX_W];

  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];
endmodule

// File: rtl/pmem_responder.sv
// Memory-side pmem_* endpoint: one line read/write at a time, with pmem_resp LATENCY cycles after acceptance.
// Requests are ignored until the in-flight transaction finishes, and one IDLE cycle always separates transactions.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY    = 8,
  parameter int LINE_IDX_W = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pmem_read,
  input  logic          pmem_write,
  input  lc3b_word      pmem_address,
  input  lc3b_cacheline pmem_wdata,
  output lc3b_cacheline pmem_rdata,
  output logic          pmem_resp,
  output logic          busy,
  output logic          proto_err
);
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  lc3b_pmem_state        state, state_nxt;
  logic [7:0]            cnt;
  logic                  op_write;
  logic [LINE_IDX_W-1:0] idx_q;
  lc3b_cacheline         wdata_q;

  logic                  req;
  logic [LINE_IDX_W-1:0] in_idx;
  logic                  enter_resp;
  logic                  eff_write;
  logic [LINE_IDX_W-1:0] eff_idx;
  lc3b_cacheline         eff_wdata;
  lc3b_cacheline         arr_rdata;
  logic                  unused_addr;

  assign req         = pmem_read | pmem_write;
  assign in_idx      = pmem_address[LINE_IDX_W+3:4];
  assign unused_addr = ^pmem_address;

  // With LATENCY==1 the commit happens on the accepting edge, so the live inputs are used instead of the latches.
  assign eff_write = (state == IDLE) ? pmem_write : op_write;
  assign eff_idx   = (state == IDLE) ? in_idx     : idx_q;
  assign eff_wdata = (state == IDLE) ? pmem_wdata : wdata_q;

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt  = (LATENCY > 1) ? WAIT : RESP;
          enter_resp = (LATENCY == 1);
        end
      end
      WAIT: begin
        if (cnt == 8'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_write <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
    end else if (state == IDLE && req) begin
      cnt      <= CNT_LOAD;
      op_write <= pmem_write;
      idx_q    <= in_idx;
      wdata_q  <= pmem_wdata;
    end else if (state == WAIT) begin
      cnt <= cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      pmem_rdata <= '0;
    else if (enter_resp && !eff_write) pmem_rdata <= arr_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         proto_err <= 1'b0;
    else if (state == IDLE && pmem_read && pmem_write) proto_err <= 1'b1;
  end

  assign pmem_resp = (state == RESP);
  assign busy      = (state != IDLE);

  pmem_line_array #(.LINE_IDX_W(LINE_IDX_W)) u_array (
    .clk   (clk),
    .we    (enter_resp & eff_write),
    .widx  (eff_idx),
    .wdata (eff_wdata),
    .ridx  (eff_idx),
    .rdata (arr_rdata)
  );
endmodule
